hex_bcd_writer: RTL and testbench

HEX_BCD_WRITER -- requirements
Module: hex_bcd_writer

---
 rtl/hex_bcd_pkg.sv | 26 ++
 rtl/bcd_adjust.sv | 17 +
 rtl/hex_bcd_writer.sv | 100 ++++++++++
 tb/tb_hex_bcd_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_bcd_pkg.sv
// Shared definitions for the hex_bcd_writer binary-to-BCD converter:
// FSM state encoding, iteration count and per-digit-count saturation limits.
package hex_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE
  } state_t;

  localparam int ITER = 32;

  // Largest value representable in N decimal digits, indexed by N
  localparam logic [31:0] MAX_VALUE [0:8] = '{
    32'd0,
    32'd9,
    32'd99,
    32'd999,
    32'd9999,
    32'd99999,
    32'd999999,
    32'd9999999,
    32'd99999999
  };

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_adjust (
  input  logic [31:0] bcd_in,
  output logic [31:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    for (int n = 0; n < 8; n++) begin
      if (bcd_in[n*4 +: 4] >= 4'd5) begin
        bcd_out[n*4 +: 4] = bcd_in[n*4 +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/hex_bcd_writer.sv
// Serial 32-bit binary to packed BCD converter feeding a display write port.
// Optional leading-zero blanking is enabled with the macro HEX_BCD_BLANK_EN.
module hex_bcd_writer
  import hex_bcd_pkg::*;
#(
  parameter int          DIGITS     = 8,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic        iCLOCK,
  input  logic        iRESET_N,
  input  logic [31:0] iVALUE,
  input  logic        iSTART,
  output logic [31:0] oDATA,
  output logic        oWR,
  output logic        oBUSY,
  output logic        oOVF
);

  state_t      state;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [31:0] bcd_adj;
  logic [5:0]  iter_q;
  logic        sat_q;
  logic [31:0] write_data;

  bcd_adjust u_adjust (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_adj)
  );

  // Saturation decision is taken at accept time so the shifting value can be consumed
  always_comb begin
`ifdef HEX_BCD_BLANK_EN
    logic leading;
`endif
    write_data = '0;
    for (int d = 0; d < 8; d++) begin
      if (d < DIGITS) begin
        write_data[d*4 +: 4] = sat_q ? 4'h9 : bcd_q[d*4 +: 4];
      end
    end
`ifdef HEX_BCD_BLANK_EN
    leading = !sat_q;
    for (int d = 7; d >= 1; d--) begin
      if (d < DIGITS) begin
        if (leading && (write_data[d*4 +: 4] == 4'h0)) begin
          write_data[d*4 +: 4] = BLANK_CODE;
        end else begin
          leading = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge iCLOCK) begin
    if (!iRESET_N) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      sat_q  <= 1'b0;
      oDATA  <= '0;
      oWR    <= 1'b0;
      oBUSY  <= 1'b0;
      oOVF   <= 1'b0;
    end else begin
      oWR <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            bin_q  <= iVALUE;
            bcd_q  <= '0;
            iter_q <= '0;
            sat_q  <= (iVALUE > MAX_VALUE[DIGITS]);
            oBUSY  <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q         <= iter_q + 6'd1;
          if (iter_q == 6'(ITER - 1)) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          oDATA <= write_data;
          oOVF  <= sat_q;
          oWR   <= 1'b1;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_bcd_writer.sv
// Directed scoreboard bench for hex_bcd_writer: an 8-digit and a 4-digit
// instance share stimulus; a division-based decimal model supplies expectations.
module tb_hex_bcd_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value = '0;

  logic [31:0] data8, data4;
  logic        wr8, wr4, busy8, busy4, ovf8, ovf4;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int exp_writes = 0;

  typedef struct packed {
    logic [31:0] d8;
    logic        o8;
    logic [31:0] d4;
    logic        o4;
  } exp_t;

  exp_t sb_q[$];

  hex_bcd_writer #(.DIGITS(8), .BLANK_CODE(4'hF)) dut8 (
    .iCLOCK   (clk),
    .iRESET_N (rst_n),
    .iVALUE   (value),
    .iSTART   (start),
    .oDATA    (data8),
    .oWR      (wr8),
    .oBUSY    (busy8),
    .oOVF     (ovf8)
  );

  hex_bcd_writer #(.DIGITS(4), .BLANK_CODE(4'hF)) dut4 (
    .iCLOCK   (clk),
    .iRESET_N (rst_n),
    .iVALUE   (value),
    .iSTART   (start),
    .oDATA    (data4),
    .oWR      (wr4),
    .oBUSY    (busy4),
    .oOVF     (ovf4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr8) wr_count++;
  end

  // Decimal reference: returns {ovf, packed digits}
  function automatic logic [32:0] model(input logic [31:0] v, input int digits);
    logic [31:0] d;
    logic [31:0] pow;
    logic        ovf;
`ifdef HEX_BCD_BLANK_EN
    bit          leading;
`endif
    d   = '0;
    pow = 32'd1;
    for (int i = 0; i < digits; i++) begin
      d[i*4 +: 4] = 4'((v / pow) % 32'd10);
      pow = pow * 32'd10;
    end
    ovf = (v > (pow - 32'd1));
    if (ovf) begin
      for (int i = 0; i < digits; i++) d[i*4 +: 4] = 4'h9;
    end
`ifdef HEX_BCD_BLANK_EN
    leading = !ovf;
    for (int i = digits - 1; i >= 1; i--) begin
      if (leading && d[i*4 +: 4] == 4'h0) d[i*4 +: 4] = 4'hF;
      else leading = 1'b0;
    end
`endif
    return {ovf, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v, input bit expect_write);
    logic [32:0] m8, m4;
    exp_t        e;
    value = v;
    start = 1'b1;
    if (expect_write) begin
      m8 = model(v, 8);
      m4 = model(v, 4);
      e.d8 = m8[31:0];
      e.o8 = m8[32];
      e.d4 = m4[31:0];
      e.o4 = m4[32];
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic waitWrite(input int elapsed, input string tag);
    int   cyc;
    exp_t e;
    cyc = elapsed;
    do begin
      tick();
      cyc++;
    end while (!wr8 && cyc < 40);
    checkOutput({tag, " latency"}, 32'(cyc), 32'd33);
    if (wr8) exp_writes++;
    if (sb_q.size() == 0) begin
      checkOutput({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, " data8"}, data8, e.d8);
      checkOutput({tag, " ovf8"}, 32'(ovf8), 32'(e.o8));
      checkOutput({tag, " data4"}, data4, e.d4);
      checkOutput({tag, " ovf4"}, 32'(ovf4), 32'(e.o4));
      checkOutput({tag, " wr4"}, 32'(wr4), 32'd1);
      checkOutput({tag, " busy_low"}, 32'(busy8), 32'd0);
    end
  endtask

  initial begin
    $display("[TB] starting hex_bcd_writer bench");
    repeat (2) tick();
    checkOutput("reset data", data8, 32'h0);
    checkOutput("reset wr", 32'(wr8), 32'd0);
    checkOutput("reset busy", 32'(busy8), 32'd0);
    checkOutput("reset ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus(32'd12345678, 1'b1);
    checkOutput("busy after accept", 32'(busy8), 32'd1);
    waitWrite(0, "v12345678");
    checkOutput("const 12345678", data8, 32'h12345678);

    applyStimulus(32'd100000000, 1'b1);
    waitWrite(0, "v100000000");
    checkOutput("const sat data", data8, 32'h99999999);
    checkOutput("const sat ovf", 32'(ovf8), 32'd1);

    applyStimulus(32'd99999999, 1'b1);
    waitWrite(0, "v99999999");
    checkOutput("const max ovf", 32'(ovf8), 32'd0);

    applyStimulus(32'd42, 1'b1);
    waitWrite(0, "v42");
`ifdef HEX_BCD_BLANK_EN
    checkOutput("const 42", data8, 32'hFFFFFF42);
`else
    checkOutput("const 42", data8, 32'h00000042);
`endif
    repeat (3) tick();
    checkOutput("hold 42", data8, model(32'd42, 8) & 33'h0FFFFFFFF);

    applyStimulus(32'd0, 1'b1);
    waitWrite(0, "v0");
`ifdef HEX_BCD_BLANK_EN
    checkOutput("const 0", data8, 32'hFFFFFFF0);
`else
    checkOutput("const 0", data8, 32'h00000000);
`endif

    applyStimulus(32'd12345, 1'b1);
    waitWrite(0, "v12345");
    checkOutput("const d4 sat", data4, 32'h00009999);
    checkOutput("const d4 ovf", 32'(ovf4), 32'd1);

    // Start during busy is dropped; start right after the write is taken
    applyStimulus(32'd1234, 1'b1);
    repeat (4) tick();
    value = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy mid shift", 32'(busy8), 32'd1);
    waitWrite(5, "v1234");
    applyStimulus(32'd86420, 1'b1);
    waitWrite(0, "b2b86420");
    repeat (40) tick();
    checkOutput("write count b2b", 32'(wr_count), 32'(exp_writes));

    applyStimulus(32'd555, 1'b0);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("abort data", data8, 32'h0);
    checkOutput("abort busy", 32'(busy8), 32'd0);
    checkOutput("abort wr", 32'(wr8), 32'd0);
    checkOutput("abort ovf", 32'(ovf8), 32'd0);
    repeat (40) tick();
    checkOutput("write count abort", 32'(wr_count), 32'(exp_writes));

    rst_n = 1'b0;
    start = 1'b1;
    value = 32'd5;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    checkOutput("reset priority busy", 32'(busy8), 32'd0);
    repeat (40) tick();
    checkOutput("write count final", 32'(wr_count), 32'(exp_writes));
    checkOutput("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
